// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P; drives an external
// point adder (doubling issued as Q+Q) and keeps Q plus an infinity flag.
module scalar_mult_ctrl #(
  parameter int n = 192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] px,
  input  logic [n-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         inf_out,
  output logic         pa_start,
  output logic [n-1:0] pa_x1,
  output logic [n-1:0] pa_y1,
  output logic [n-1:0] pa_x2,
  output logic [n-1:0] pa_y2,
  input  logic [n-1:0] pa_x3,
  input  logic [n-1:0] pa_y3,
  input  logic         pa_result,
  input  logic         pa_infinity
);

  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {
    IDLE, BIT, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE
  } state_t;

  state_t          state;
  logic [n-1:0]    k_r, px_r, py_r;
  logic [n-1:0]    qx, qy;
  logic            q_inf;
  logic [IW-1:0]   idx;
  logic            bit_set, last, resp;

  always_comb begin
    bit_set = k_r[idx];
    last    = (idx == '0);
    resp    = pa_result | pa_infinity;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      inf_out  <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      pa_start <= 1'b0;
      pa_x1    <= '0;
      pa_y1    <= '0;
      pa_x2    <= '0;
      pa_y2    <= '0;
      k_r      <= '0;
      px_r     <= '0;
      py_r     <= '0;
      qx       <= '0;
      qy       <= '0;
      q_inf    <= 1'b1;
      idx      <= '0;
    end else begin
      done     <= 1'b0;
      pa_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_r   <= k;
            px_r  <= px;
            py_r  <= py;
            q_inf <= 1'b1;
            idx   <= IW'(n - 1);
            busy  <= 1'b1;
            state <= BIT;
          end
        end
        BIT: begin
          if (q_inf) begin
            if (bit_set) begin
              qx    <= px_r;
              qy    <= py_r;
              q_inf <= 1'b0;
            end
            state <= last ? DONE : BIT;
            if (!last) idx <= idx - 1'b1;
          end else begin
            pa_x1    <= qx;
            pa_y1    <= qy;
            pa_x2    <= qx;
            pa_y2    <= qy;
            pa_start <= 1'b1;
            state    <= DBL_REQ;
          end
        end
        DBL_REQ: state <= DBL_WAIT;
        ADD_REQ: state <= ADD_WAIT;
        DBL_WAIT: begin
          if (resp) begin
            if (pa_infinity) begin
              // 2Q = O, so O + P collapses to loading P directly
              if (bit_set) begin
                qx    <= px_r;
                qy    <= py_r;
                q_inf <= 1'b0;
              end else begin
                q_inf <= 1'b1;
              end
              state <= last ? DONE : BIT;
              if (!last) idx <= idx - 1'b1;
            end else begin
              qx <= pa_x3;
              qy <= pa_y3;
              if (bit_set) begin
                pa_x1    <= pa_x3;
                pa_y1    <= pa_y3;
                pa_x2    <= px_r;
                pa_y2    <= py_r;
                pa_start <= 1'b1;
                state    <= ADD_REQ;
              end else begin
                state <= last ? DONE : BIT;
                if (!last) idx <= idx - 1'b1;
              end
            end
          end
        end
        ADD_WAIT: begin
          if (resp) begin
            if (pa_infinity) begin
              q_inf <= 1'b1;
            end else begin
              qx <= pa_x3;
              qy <= pa_y3;
            end
            state <= last ? DONE : BIT;
            if (!last) idx <= idx - 1'b1;
          end
        end
        DONE: begin
          x_out   <= q_inf ? '0 : qx;
          y_out   <= q_inf ? '0 : qy;
          inf_out <= q_inf;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
